// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60Hz VGA raster timing generator with registered pin stage
//
// Ports:
//   CLOCK_25   in   1   pixel clock; all state updates on the rising edge
//   reset      in   1   synchronous, active-high
//   x          out  12  pixel column (1-based), 0 while blanking
//   y          out  12  pixel row (1-based), 0 while blanking
//   active     out  1   current counter position is inside the visible area
//   frame_tick out  1   one-clock pulse the cycle after the last visible pixel
//   color_in   in   3   colour for the current x/y from the image generator
//   vga_color  out  3   registered, blanked colour to the DAC/pins
//   vga_hs     out  1   registered horizontal sync
//   vga_vs     out  1   registered vertical sync

module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_tick,
  input  logic [2:0]  color_in,
  output logic [2:0]  vga_color,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 12-bit versions of the timing landmarks so every compare is width-matched.
  localparam logic [11:0] H_ACT_W   = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST_W  = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_BEG_W  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_W  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_W   = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST_W  = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_BEG_W  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_W  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_LVIS_W  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LVIS_W  = 12'(V_ACTIVE - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        h_last;
  logic        v_last;
  logic        hs_on;
  logic        vs_on;
  logic        last_visible;

  // Raster counters. v_cnt only moves on the last clock of a line, so the
  // pair walks the frame in raster order and can never leave its range.
  assign h_last = (h_cnt == H_LAST_W);
  assign v_last = (v_cnt == V_LAST_W);

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else begin
      if (h_last) begin
        h_cnt <= 12'd0;
        if (v_last) begin
          v_cnt <= 12'd0;
        end else begin
          v_cnt <= v_cnt + 12'd1;
        end
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  // Coordinates are decoded straight from the counters so the image
  // generator sees the position for this clock; its colour is then captured
  // by the output register together with the syncs for the same position.
  always_comb begin
    active = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
    x      = 12'd0;
    y      = 12'd0;
    if (active) begin
      x = h_cnt + 12'd1;
      y = v_cnt + 12'd1;
    end
  end

  assign hs_on        = (h_cnt >= HS_BEG_W) && (h_cnt < HS_END_W);
  assign vs_on        = (v_cnt >= VS_BEG_W) && (v_cnt < VS_END_W);
  assign last_visible = (h_cnt == H_LVIS_W) && (v_cnt == V_LVIS_W);

  // Pin stage: colour and both syncs share one register so they leave the
  // chip on the same edge. Reset forces the syncs idle immediately, which
  // cuts off any sync pulse that was in progress.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      vga_color  <= 3'b000;
      vga_hs     <= ~SYNC_POL;
      vga_vs     <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      vga_color  <= active ? color_in : 3'b000;
      vga_hs     <= hs_on ? SYNC_POL : ~SYNC_POL;
      vga_vs     <= vs_on ? SYNC_POL : ~SYNC_POL;
      frame_tick <= last_visible;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench for vga_timing (full horizontal timing, shortened vertical)

module tb_vga_timing;

  // Vertical timing is shrunk so several frames fit in a short run; the
  // horizontal timing is the real 800-clock line.
  localparam int VA    = 6;
  localparam int VFP   = 2;
  localparam int VSW   = 2;
  localparam int VBP   = 3;
  localparam int FRAME = 800 * (VA + VFP + VSW + VBP);  // 10400

  logic        CLOCK_25 = 1'b0;
  logic        reset    = 1'b1;
  logic [2:0]  color_in = 3'b111;
  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        frame_tick;
  logic [2:0]  vga_color;
  logic        vga_hs;
  logic        vga_vs;

  int k = 0;
  int n_checks = 0;
  int n_pass = 0;

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .CLOCK_25  (CLOCK_25),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .active    (active),
    .frame_tick(frame_tick),
    .color_in  (color_in),
    .vga_color (vga_color),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
  endtask

  // All sampling happens on the falling edge; k is the number of rising
  // edges since reset was released, i.e. the counters hold (k%800, k/800).
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLOCK_25);
    k += n;
  endtask

  task automatic tick_to(input int target);
    if (target > k) tick(target - k);
  endtask

  initial begin
    int len;
    int per;
    int ft_cnt;
    int ft_k;
    int ft_k2;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) @(negedge CLOCK_25);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_color", vga_color, 0);
    check("rst_ft", frame_tick, 0);
    check("rst_x", x, 1);
    check("rst_y", y, 1);
    check("rst_active", active, 1);
    reset = 1'b0;
    k = 0;

    // First pixel colour appears one clock after position (0,0).
    tick(1);
    check("color_first", vga_color, 3'b111);
    check("x_second", x, 2);

    // Colour change at h=100 shows exactly one clock later.
    tick_to(100);
    check("color_pre_toggle", vga_color, 3'b111);
    color_in = 3'b010;
    tick(1);
    check("color_toggle", vga_color, 3'b010);
    color_in = 3'b111;
    tick(1);
    check("color_restore", vga_color, 3'b111);

    // Horizontal visible edge.
    tick_to(639);
    check("x_639", x, 640);
    check("y_639", y, 1);
    check("act_639", active, 1);
    tick(1);
    check("x_640", x, 0);
    check("y_640", y, 0);
    check("act_640", active, 0);
    check("color_last_vis", vga_color, 3'b111);
    tick(1);
    check("color_blank", vga_color, 3'b000);

    // Horizontal sync: falls the clock after h=656, 96 clocks wide, 800 period.
    tick_to(656);
    check("hs_before", vga_hs, 1);
    tick(1);
    check("hs_fall", vga_hs, 0);
    len = 0;
    while (vga_hs == 1'b0 && len < 200) begin tick(1); len++; end
    check("hs_width", len, 96);
    per = 0;
    while (vga_hs == 1'b1 && per < 1000) begin tick(1); per++; end
    check("line_period", len + per, 800);

    // Third line, column 6.
    tick_to(1605);
    check("x_l3", x, 6);
    check("y_l3", y, 3);

    // frame_tick once, right after (639, VA-1); y blank on line VA.
    ft_cnt = 0;
    ft_k = -1;
    while (k < 6000) begin
      tick(1);
      if (frame_tick) begin ft_cnt++; ft_k = k; end
      if (k == VA * 800) check("y_vblank_h0", y, 0);
      if (k == VA * 800 + 100) check("y_vblank_h100", y, 0);
      if (k == VA * 800 + 100) check("act_vblank", active, 0);
    end
    check("ft_count", ft_cnt, 1);
    check("ft_pos", ft_k, (VA - 1) * 800 + 640);

    // Vertical sync: starts one clock after (0, VA+VFP), 1600 clocks long.
    tick_to((VA + VFP) * 800);
    check("vs_before", vga_vs, 1);
    tick(1);
    check("vs_fall", vga_vs, 0);
    len = 0;
    while (vga_vs == 1'b0 && len < 2000) begin tick(1); len++; end
    check("vs_width", len, 1600);

    // Frame period via the next frame_tick.
    ft_cnt = 0;
    ft_k2 = -1;
    while (k < ft_k + FRAME + 60) begin
      tick(1);
      if (frame_tick) begin ft_cnt++; ft_k2 = k; end
    end
    check("ft_count2", ft_cnt, 1);
    check("frame_period", ft_k2 - ft_k, FRAME);

    // Mid-frame reset at (700, VA+VFP+1) with both syncs active.
    tick_to(FRAME + (VA + VFP + 1) * 800 + 700);
    check("mid_hs_active", vga_hs, 0);
    check("mid_vs_active", vga_vs, 0);
    reset = 1'b1;
    tick(1);
    check("mid_rst_hs", vga_hs, 1);
    check("mid_rst_vs", vga_vs, 1);
    check("mid_rst_x", x, 1);
    check("mid_rst_y", y, 1);
    check("mid_rst_color", vga_color, 0);
    reset = 1'b0;
    k = 0;
    len = 0;
    while (vga_hs == 1'b1 && len < 1000) begin tick(1); len++; end
    check("hs_after_reset", len, 657);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
